// File: rtl/tmr_pkg.sv
// ---------------------------------------------------------------------------
// tmr_pkg : channel indices and voting helpers shared by the TMR voter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tmr_pkg;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;

  // Widest channel the helpers accept; callers size-cast in and out.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] maj3(input logic [MAX_W-1:0] x,
                                            input logic [MAX_W-1:0] y,
                                            input logic [MAX_W-1:0] z);
    return (x & y) | (y & z) | (z & x);
  endfunction

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/tmr_chan_monitor.sv
// ---------------------------------------------------------------------------
// tmr_chan_monitor : per-channel mismatch run tracker, error counter, fault
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tmr_chan_monitor
  import tmr_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int FAULT_THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             mm,
  input  logic             clr,
  output logic             fault,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [3:0]       c_thresh  = 4'(FAULT_THRESH);
  localparam logic [CNT_W-1:0] c_err_max = {CNT_W{1'b1}};

  logic [3:0]       r_run;
  logic [CNT_W-1:0] r_err;
  logic             r_fault;
  logic [3:0]       w_run_inc;

  assign w_run_inc = (r_run == c_thresh) ? r_run : r_run + 4'd1;

  // clr outranks a coincident sample; gaps (valid=0) leave the run intact.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_run   <= '0;
      r_err   <= '0;
      r_fault <= 1'b0;
    end else if (valid) begin
      if (mm) begin
        r_run <= w_run_inc;
        if (r_err != c_err_max) begin
          r_err <= r_err + 1'b1;
        end
        if (w_run_inc == c_thresh) begin
          r_fault <= 1'b1;
        end
      end else begin
        r_run <= '0;
      end
    end
  end

  assign fault   = r_fault;
  assign err_cnt = r_err;

endmodule

`default_nettype wire

// File: rtl/tmr_vote_reg.sv
// ---------------------------------------------------------------------------
// tmr_vote_reg : registered TMR majority voter with fault masking
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tmr_vote_reg
  import tmr_pkg::*;
#(
  parameter int W            = 4,
  parameter int CNT_W        = 8,
  parameter int FAULT_THRESH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [W-1:0]       c,
  input  logic               clr_fault,
  output logic               out_valid,
  output logic [W-1:0]       y,
  output logic [2:0]         mismatch,
  output logic               uncorrectable,
  output logic [2:0]         fault,
  output logic [3*CNT_W-1:0] err_cnt
);

  logic [W-1:0] w_ch [3];
  logic [W-1:0] w_m;
  logic [2:0]   w_mm;
  logic [2:0]   w_fault;
  logic [W-1:0] w_y_next;
  logic         w_unc_next;

  logic         r_out_valid;
  logic [W-1:0] r_y;
  logic [2:0]   r_mismatch;
  logic         r_unc;

  assign w_ch[CH_A] = a;
  assign w_ch[CH_B] = b;
  assign w_ch[CH_C] = c;

  assign w_m = W'(maj3(MAX_W'(a), MAX_W'(b), MAX_W'(c)));

  generate
    for (genvar k = 0; k < 3; k++) begin : g_chan
      // Faulty channels stay monitored against the unmasked majority.
      assign w_mm[k] = (w_ch[k] != w_m);

      tmr_chan_monitor #(
        .CNT_W        (CNT_W),
        .FAULT_THRESH (FAULT_THRESH)
      ) u_mon (
        .clk     (clk),
        .rst     (rst),
        .valid   (in_valid),
        .mm      (w_mm[k]),
        .clr     (clr_fault),
        .fault   (w_fault[k]),
        .err_cnt (err_cnt[k*CNT_W +: CNT_W])
      );
    end
  endgenerate

  // The vote uses the fault mask as it stood before this edge.
  always_comb begin
    w_y_next   = r_y;
    w_unc_next = 1'b1;
    case (w_fault)
      3'b000: begin
        w_y_next   = w_m;
        w_unc_next = (popcount3(w_mm) >= 2'd2);
      end
      3'b001: begin
        if (b == c) begin
          w_y_next   = b;
          w_unc_next = 1'b0;
        end
      end
      3'b010: begin
        if (a == c) begin
          w_y_next   = a;
          w_unc_next = 1'b0;
        end
      end
      3'b100: begin
        if (a == b) begin
          w_y_next   = a;
          w_unc_next = 1'b0;
        end
      end
      3'b011:  w_y_next = c;
      3'b101:  w_y_next = b;
      3'b110:  w_y_next = a;
      default: w_y_next = r_y;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_mismatch  <= '0;
      r_unc       <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_y        <= w_y_next;
        r_mismatch <= w_mm;
        r_unc      <= w_unc_next;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign y             = r_y;
  assign mismatch      = r_mismatch;
  assign uncorrectable = r_unc;
  assign fault         = w_fault;

endmodule

`default_nettype wire

// File: tb/tb_tmr_vote_reg.sv
// ---------------------------------------------------------------------------
// tb_tmr_vote_reg : scoreboard bench for the registered TMR voter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tmr_vote_reg;

  localparam int W     = 4;
  localparam int CNT_W = 8;
  localparam int TH    = 3;
  localparam int EMAX  = 255;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [W-1:0]       a, b, c;
  logic               clr_fault;
  logic               out_valid;
  logic [W-1:0]       y;
  logic [2:0]         mismatch;
  logic               uncorrectable;
  logic [2:0]         fault;
  logic [3*CNT_W-1:0] err_cnt;

  tmr_vote_reg #(.W(W), .CNT_W(CNT_W), .FAULT_THRESH(TH)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .a             (a),
    .b             (b),
    .c             (c),
    .clr_fault     (clr_fault),
    .out_valid     (out_valid),
    .y             (y),
    .mismatch      (mismatch),
    .uncorrectable (uncorrectable),
    .fault         (fault),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] y;
    logic [2:0]   mm;
    logic         unc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  logic [2:0]   m_fault;
  int           m_run [3];
  int           m_errc[3];
  logic [W-1:0] m_y;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fault = '0;
    m_y     = '0;
    for (int k = 0; k < 3; k++) begin
      m_run[k]  = 0;
      m_errc[k] = 0;
    end
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; clr_fault = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_y", 32'(y), 32'd0);
    check_val("rst_mismatch", 32'(mismatch), 32'd0);
    check_val("rst_unc", 32'(uncorrectable), 32'd0);
    check_val("rst_fault", 32'(fault), 32'd0);
    check_val("rst_err_cnt", 32'(err_cnt), 32'd0);
  endtask

  task automatic step(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [W-1:0] ic, input logic clr);
    logic [W-1:0] ch[3];
    logic [W-1:0] mj;
    logic [2:0]   mm;
    logic [W-1:0] ny;
    logic         nu;
    int           hl[$];
    exp_t         e;
    @(negedge clk);
    in_valid = v; a = ia; b = ib; c = ic; clr_fault = clr;
    if (v) begin
      ch[0] = ia; ch[1] = ib; ch[2] = ic;
      for (int i = 0; i < W; i++)
        mj[i] = ((int'(ia[i]) + int'(ib[i]) + int'(ic[i])) >= 2);
      for (int k = 0; k < 3; k++) mm[k] = (ch[k] != mj);
      for (int k = 0; k < 3; k++) if (!m_fault[k]) hl.push_back(k);
      ny = m_y; nu = 1'b1;
      if (hl.size() == 3) begin
        ny = mj; nu = ($countones(mm) >= 2);
      end else if (hl.size() == 2) begin
        if (ch[hl[0]] == ch[hl[1]]) begin ny = ch[hl[0]]; nu = 1'b0; end
      end else if (hl.size() == 1) begin
        ny = ch[hl[0]];
      end
      m_y = ny;
      sb.push_back('{y: ny, mm: mm, unc: nu});
      for (int k = 0; k < 3; k++) begin
        if (mm[k]) begin
          m_run[k]  = (m_run[k] + 1 > TH) ? TH : m_run[k] + 1;
          m_errc[k] = (m_errc[k] + 1 > EMAX) ? EMAX : m_errc[k] + 1;
          if (m_run[k] == TH) m_fault[k] = 1'b1;
        end else begin
          m_run[k] = 0;
        end
      end
    end
    if (clr) begin
      m_fault = '0;
      for (int k = 0; k < 3; k++) begin
        m_run[k] = 0; m_errc[k] = 0;
      end
    end
    @(posedge clk); #1;
    check_val("out_valid", 32'(out_valid), 32'(v));
    if (out_valid) begin
      if (sb.size() == 0) begin
        check_val("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("y", 32'(y), 32'(e.y));
        check_val("mismatch", 32'(mismatch), 32'(e.mm));
        check_val("unc", 32'(uncorrectable), 32'(e.unc));
      end
    end
    check_val("fault", 32'(fault), 32'(m_fault));
    check_val("err_cnt", 32'(err_cnt),
              32'({8'(m_errc[2]), 8'(m_errc[1]), 8'(m_errc[0])}));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; clr_fault = 1'b0; a = '0; b = '0; c = '0;
    do_reset();

    // Clean sample, then an idle cycle holding y.
    step(1'b1, 4'hA, 4'hA, 4'hA, 1'b0);
    check_val("basic_y", 32'(y), 32'hA);
    check_val("basic_mm", 32'(mismatch), 32'd0);
    step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    check_val("idle_hold_y", 32'(y), 32'hA);

    // Single upset on channel c.
    step(1'b1, 4'h5, 4'h5, 4'hF, 1'b0);
    check_val("upset_y", 32'(y), 32'h5);
    check_val("upset_mm", 32'(mismatch), 32'b100);
    check_val("upset_errc", 32'(err_cnt[2*CNT_W +: CNT_W]), 32'd1);

    // Three c mismatches separated by idle gaps latch the fault.
    do_reset();
    step(1'b1, 4'h0, 4'h0, 4'h1, 1'b0);
    step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1'b1, 4'h2, 4'h2, 4'h3, 1'b0);
    step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1'b1, 4'h4, 4'h4, 4'h5, 1'b0);
    check_val("fault_c", 32'(fault), 32'b100);
    step(1'b1, 4'h3, 4'h3, 4'h3, 1'b0);
    check_val("masked_y", 32'(y), 32'h3);
    step(1'b1, 4'h1, 4'h2, 4'h2, 1'b0);
    check_val("split_hold_y", 32'(y), 32'h3);
    check_val("split_unc", 32'(uncorrectable), 32'd1);
    check_val("split_mm", 32'(mismatch), 32'b001);

    // Broken run never reaches the threshold.
    do_reset();
    step(1'b1, 4'h1, 4'h1, 4'h0, 1'b0);
    step(1'b1, 4'h1, 4'h1, 4'h0, 1'b0);
    step(1'b1, 4'h1, 4'h1, 4'h1, 1'b0);
    step(1'b1, 4'h1, 4'h1, 4'h0, 1'b0);
    step(1'b1, 4'h1, 4'h1, 4'h0, 1'b0);
    check_val("run_break_fault", 32'(fault), 32'd0);
    check_val("run_break_errc", 32'(err_cnt[2*CNT_W +: CNT_W]), 32'd4);

    // Error counter saturation, then clear alongside a mismatching sample.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 4'(i), 4'(i), ~4'(i), 1'b0);
    end
    check_val("sat_errc", 32'(err_cnt[2*CNT_W +: CNT_W]), 32'd255);
    step(1'b1, 4'h6, 4'h6, 4'h9, 1'b1);
    check_val("clr_fault", 32'(fault), 32'd0);
    check_val("clr_err_cnt", 32'(err_cnt), 32'd0);
    check_val("clr_y", 32'(y), 32'h6);

    // Latch faults on b and c, then reset mid-state.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 4'h0, 4'h1, 4'h2, 1'b0);
    check_val("fault_bc", 32'(fault), 32'b110);
    do_reset();

    // Random traffic with occasional clears.
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
           4'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
